// File: rtl/mic_level_meter.sv
// mic_level_meter: windowed peak magnitude of the mic stream quantised to 0..15, plus a peak-hold marker level
module mic_level_meter #(
    parameter int SAMPLE_W     = 12,
    parameter int MIDSCALE     = 2048,
    parameter int WINDOW       = 4000,
    parameter int HOLD_WINDOWS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                freeze,
    output logic [3:0]          level,
    output logic                level_valid,
    output logic [3:0]          peak_level
);
    localparam int CW = $clog2(WINDOW + 1);
    localparam int HW = $clog2(HOLD_WINDOWS + 1);
    typedef enum logic {HOLD, DECAY} state_t;
    state_t                state, state_n;
    logic [CW-1:0]         cnt;
    logic [HW-1:0]         hold_cnt, hold_n;
    logic [10:0]           run_max, amp, win_max;
    logic [3:0]            q, peak_n, peak_dec;
    logic signed [SAMPLE_W:0] diff;
    logic [SAMPLE_W:0]     mag;
    logic                  win_end, update, holding;
    assign diff     = $signed({1'b0, sample}) - $signed((SAMPLE_W + 1)'(MIDSCALE));
    assign mag      = $unsigned(diff[SAMPLE_W] ? -diff : diff);
    assign amp      = (mag > (SAMPLE_W + 1)'(2047)) ? 11'd2047 : mag[10:0];
    assign win_max  = (amp > run_max) ? amp : run_max;
    assign q        = win_max[10:7];
    assign win_end  = sample_valid && (cnt == CW'(WINDOW - 1));
    assign update   = win_end && !freeze;
    assign holding  = (state == HOLD) && (hold_cnt != '0);
    assign peak_dec = ({1'b0, peak_level} > ({1'b0, q} + 5'd1)) ? peak_level - 4'd1 : q;
    // window counter and running max advance only on valid samples; the closing sample is not carried over
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            run_max <= '0;
        end else if (sample_valid) begin
            cnt     <= win_end ? '0 : cnt + 1'b1;
            run_max <= win_end ? '0 : win_max;
        end
    end
    // state register: outputs and peak FSM move only on non-frozen window ends
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            level       <= '0;
            peak_level  <= '0;
            level_valid <= 1'b0;
        end else begin
            level_valid <= update;
            if (update) begin
                state      <= state_n;
                hold_cnt   <= hold_n;
                level      <= q;
                peak_level <= peak_n;
            end
        end
    end
    // next state: a new high re-arms the hold, otherwise count down the hold then decay until back at q
    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        if (q >= peak_level) begin
            state_n = HOLD;
            hold_n  = HW'(HOLD_WINDOWS);
        end else if (holding) begin
            hold_n = hold_cnt - 1'b1;
        end else if (state == HOLD) begin
            state_n = DECAY;
        end else if (peak_dec == q) begin
            state_n = HOLD;
            hold_n  = HW'(HOLD_WINDOWS);
        end
    end
    // peak output: jump up to q, stay while holding, else step down by one but never below q
    always_comb begin
        peak_n = (q >= peak_level) ? q : holding ? peak_level : peak_dec;
    end
endmodule

// File: tb/tb_mic_level_meter.sv
// tb_mic_level_meter: randomized scoreboard bench for mic_level_meter against a window-list reference model
module tb_mic_level_meter;
    localparam int WINDOW = 4;
    localparam int HOLDW  = 2;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic        freeze = 1'b0;
    logic [11:0] sample = 12'd2048;
    logic [3:0]  level, peak_level;
    logic        level_valid;
    int checks = 0;
    int errors = 0;
    typedef struct {int lvl; int pk;} exp_t;
    exp_t sbq[$];
    int   m_win[$];
    int   m_lvl = 0, m_peak = 0, m_hold = 0;
    bit   m_decay = 0, m_pushed = 0;

    mic_level_meter #(.SAMPLE_W(12), .MIDSCALE(2048), .WINDOW(WINDOW), .HOLD_WINDOWS(HOLDW)) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
        .freeze(freeze), .level(level), .level_valid(level_valid), .peak_level(peak_level)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int mag(input int s);
        int a;
        a = s - 2048;
        if (a < 0) a = -a;
        return (a > 2047) ? 2047 : a;
    endfunction

    // reference model: keep the window's magnitudes in a list, apply peak rules on each completed window
    task automatic model_edge(input bit v, input int s);
        int mx, q;
        m_pushed = 0;
        if (reset) begin
            m_win.delete();
            m_lvl = 0; m_peak = 0; m_hold = 0; m_decay = 0;
            return;
        end
        if (!v) return;
        m_win.push_back(mag(s));
        if (m_win.size() != WINDOW) return;
        mx = 0;
        foreach (m_win[i]) if (m_win[i] > mx) mx = m_win[i];
        m_win.delete();
        q = mx / 128;
        if (freeze) return;
        if (q >= m_peak) begin
            m_peak = q; m_hold = HOLDW; m_decay = 0;
        end else if (!m_decay && m_hold > 0) begin
            m_hold--;
        end else if (!m_decay) begin
            m_decay = 1;
            m_peak = (m_peak - 1 > q) ? m_peak - 1 : q;
        end else begin
            m_peak = (m_peak - 1 > q) ? m_peak - 1 : q;
            if (m_peak == q) begin m_decay = 0; m_hold = HOLDW; end
        end
        m_lvl = q;
        sbq.push_back('{m_lvl, m_peak});
        m_pushed = 1;
    endtask

    task automatic step(input bit v, input int s);
        sample_valid = v;
        sample = 12'(s);
        @(posedge clk);
        model_edge(v, s);
        #1;
        check("level", level, m_lvl);
        check("peak_level", peak_level, m_peak);
        check("level_valid", level_valid, m_pushed);
        check("peak_ge_level", peak_level >= level, 1);
    endtask

    task automatic win(input int a, input int b, input int c, input int d, input int maxgap);
        int s[4];
        s = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            if (i != 0) repeat ($urandom_range(0, maxgap)) step(0, 4095);
            step(1, s[i]);
        end
    endtask

    function automatic int rnd_sample(input int span);
        int v;
        v = 2048 - span + int'($urandom_range(0, 2 * span));
        return (v < 0) ? 0 : (v > 4095) ? 4095 : v;
    endfunction

    // scoreboard monitor: every level_valid pulse must match the oldest expected update
    always @(negedge clk) begin
        exp_t e;
        if (level_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_valid: got level %0d peak %0d expected no update", level, peak_level);
            end else begin
                e = sbq.pop_front();
                check("sb_level", level, e.lvl);
                check("sb_peak", peak_level, e.pk);
            end
        end
    end

    initial begin
        int lv, pk, n, span;
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            step(1, int'($urandom_range(0, 4095)));
            check("reset_level", level, 0);
            check("reset_peak", peak_level, 0);
            check("reset_valid", level_valid, 0);
        end
        reset = 0;
        step(0, 2048);
        check("post_reset_level", level, 0);
        check("post_reset_valid", level_valid, 0);

        win(2048, 2300, 1800, 2048, 0);
        check("basic_level", level, 1);
        check("basic_valid", level_valid, 1);
        check("basic_peak", peak_level, 1);
        step(0, 2048);
        check("basic_valid_one_cycle", level_valid, 0);

        win(4095, 4095, 4095, 4095, 0);
        check("max_level", level, 15);
        win(0, 2048, 2048, 2048, 0);
        check("clamp_level", level, 15);
        win(2048, 2048, 2048, 2048, 0);
        check("silence_level", level, 0);

        win(2048, 2048, 2048, 2048, 5);
        check("gapped_level", level, 0);
        check("gapped_valid", level_valid, 1);

        reset = 1; step(0, 2048); reset = 0;
        win(4095, 4095, 4095, 4095, 0);
        n = 1;
        check("decay_peak", peak_level, 15);
        check("decay_level", level, 15);
        repeat (17) begin
            win(2048, 2048, 2048, 2048, 1);
            n++;
            check("decay_peak", peak_level, (n <= 3) ? 15 : 15 - (n - 3));
            check("decay_level", level, 0);
        end

        win(3000, 1000, 2048, 2048, 0);
        lv = level; pk = peak_level;
        freeze = 1;
        win(4095, 0, 4095, 4095, 2);
        win(2048, 2048, 2048, 2048, 2);
        check("freeze_level", level, lv);
        check("freeze_peak", peak_level, pk);
        freeze = 0;
        win(2600, 2048, 2048, 2048, 1);
        check("unfreeze_level", level, 4);
        check("unfreeze_valid", level_valid, 1);

        step(1, 4095); step(1, 4095);
        reset = 1; step(0, 2048); reset = 0;
        win(2048, 2048, 2048, 2048, 0);
        check("reset_mid_window_level", level, 0);

        for (int w = 0; w < 80; w++) begin
            freeze = ($urandom_range(0, 5) == 0);
            span = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2048)) : int'($urandom_range(0, 600));
            if ($urandom_range(0, 19) == 0) begin
                step(1, rnd_sample(span));
                reset = 1; step(1, rnd_sample(span)); reset = 0;
            end
            win(rnd_sample(span), rnd_sample(span), rnd_sample(span), rnd_sample(span), 3);
        end
        freeze = 0;

        for (int i = 0; i < 5 && sbq.size() != 0; i++) step(0, 2048);
        check("scoreboard_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
